time_set_ctrl: RTL and testbench

Button-driven time-setting controller. It is the writer side of the clock counter's time-overwrite interface. It captures the running time, lets the user edit hours, minutes and seconds with mode/inc/dec buttons, then drives a stable `time_set` word and a one-cycle `time_ow` pulse that loads the edited time into the counter. It runs on the fast system clock and sits between the debounced front-panel buttons and the counter's `time_in`/`time_ow` inputs.

---
 rtl/time_set_ctrl.sv | 168 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: captures the running time, edits h/m/s
// with mode/inc/dec buttons and commits it through a one-cycle overwrite pulse.
module time_set_ctrl #(
  parameter int TIMEOUT_CYC = 10_000_000,
  parameter int BLINK_CYC   = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [16:0] time_cur,
  output logic [16:0] time_set,
  output logic        time_ow,
  output logic        set_active,
  output logic [1:0]  field_sel,
  output logic        blink
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_HOUR, S_MIN, S_SEC, S_COMMIT} state_t;

  state_t        state;
  logic [4:0]    edit_h;
  logic [5:0]    edit_m, edit_s;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;

  // Bit order {dec, inc, mode} throughout the button path.
  logic [2:0] btn, sync1, sync2, dly, ev;
  assign btn = {btn_dec, btn_inc, btn_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign ev = sync2 & ~dly;

  logic ev_mode, ev_any, step_up, step_dn;
  assign ev_mode = ev[0];
  assign ev_any  = |ev;
  assign step_up = ev[1] & ~ev[2];
  assign step_dn = ev[2] & ~ev[1];

  function automatic logic [4:0] step5(input logic [4:0] v, input logic up, input logic dn);
    logic [4:0] r;
    r = v;
    if (up)      r = (v == 5'd23) ? 5'd0 : v + 5'd1;
    else if (dn) r = (v == 5'd0) ? 5'd23 : v - 5'd1;
    return r;
  endfunction

  function automatic logic [5:0] step6(input logic [5:0] v, input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up)      r = (v == 6'd59) ? 6'd0 : v + 6'd1;
    else if (dn) r = (v == 6'd0) ? 6'd59 : v - 6'd1;
    return r;
  endfunction

  // Out-of-range captured fields are replaced by zero.
  logic [4:0] cap_h;
  logic [5:0] cap_m, cap_s;
  assign cap_h = (time_cur[16:12] > 5'd23) ? 5'd0 : time_cur[16:12];
  assign cap_m = (time_cur[11:6]  > 6'd59) ? 6'd0 : time_cur[11:6];
  assign cap_s = (time_cur[5:0]   > 6'd59) ? 6'd0 : time_cur[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      edit_h     <= '0;
      edit_m     <= '0;
      edit_s     <= '0;
      tcnt       <= '0;
      bcnt       <= '0;
      time_ow    <= 1'b0;
      set_active <= 1'b0;
      field_sel  <= 2'd0;
      blink      <= 1'b0;
    end else begin
      time_ow <= 1'b0;
      tcnt    <= tcnt + TW'(1);
      if (bcnt == B_LAST) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt <= bcnt + BW'(1);
      end

      case (state)
        S_IDLE: begin
          tcnt  <= '0;
          bcnt  <= '0;
          blink <= 1'b0;
          if (ev_mode) begin
            edit_h     <= cap_h;
            edit_m     <= cap_m;
            edit_s     <= cap_s;
            state      <= S_HOUR;
            set_active <= 1'b1;
            field_sel  <= 2'd1;
            blink      <= 1'b1;
          end
        end

        S_HOUR, S_MIN, S_SEC: begin
          if (ev_mode) begin
            tcnt  <= '0;
            bcnt  <= '0;
            blink <= 1'b1;
            case (state)
              S_HOUR: begin
                state     <= S_MIN;
                field_sel <= 2'd2;
              end
              S_MIN: begin
                state     <= S_SEC;
                field_sel <= 2'd3;
              end
              default: begin
                state     <= S_COMMIT;
                field_sel <= 2'd0;
                blink     <= 1'b0;
                time_ow   <= 1'b1;
              end
            endcase
          end else if (ev_any) begin
            // inc+dec together only restarts the timeout.
            tcnt <= '0;
            case (state)
              S_HOUR:  edit_h <= step5(edit_h, step_up, step_dn);
              S_MIN:   edit_m <= step6(edit_m, step_up, step_dn);
              default: edit_s <= step6(edit_s, step_up, step_dn);
            endcase
          end else if (tcnt == T_LAST) begin
            state      <= S_IDLE;
            set_active <= 1'b0;
            field_sel  <= 2'd0;
            blink      <= 1'b0;
            bcnt       <= '0;
          end
        end

        default: begin
          state      <= S_IDLE;
          set_active <= 1'b0;
          field_sel  <= 2'd0;
          blink      <= 1'b0;
          bcnt       <= '0;
          tcnt       <= '0;
        end
      endcase
    end
  end

  assign time_set = {edit_h, edit_m, edit_s};
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios with literal expectations plus
// randomized buttons checked every cycle against an edge-indexed behavioural model.
module tb_time_set_ctrl;
  localparam int TO = 100;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [16:0] time_cur = '0;
  logic [16:0] time_set;
  logic        time_ow, set_active, blink;
  logic [1:0]  field_sel;

  time_set_ctrl #(.TIMEOUT_CYC(TO), .BLINK_CYC(BL)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .time_cur(time_cur), .time_set(time_set), .time_ow(time_ow),
    .set_active(set_active), .field_sel(field_sel), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int word(input int h, input int m, input int s);
    return h * 4096 + m * 64 + s;
  endfunction

  // Model: phase 0 idle, 1..3 editing field phase-1, 4 commit.
  // Button levels are remembered per edge; the event acted on at edge n
  // is "high at edge n-2 and low at edge n-3".
  int       m_phase = 0;
  int       m_f[3] = '{0, 0, 0};
  bit       m_ow = 0;
  longint   n_edge = 0, m_entry = 0, m_last = 0;
  bit [2:0] s1 = 0, s2 = 0, s3 = 0, m_ev;
  int       cap, lim;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_f = '{0, 0, 0}; m_ow = 0;
      s1 = 0; s2 = 0; s3 = 0;
      n_edge = 0; m_entry = 0; m_last = 0;
    end else begin
      n_edge++;
      m_ev = s2 & ~s3;
      m_ow = 0;
      if (m_phase == 0) begin
        if (m_ev[0]) begin
          cap = int'(time_cur);
          m_f[0] = cap / 4096;        if (m_f[0] > 23) m_f[0] = 0;
          m_f[1] = (cap / 64) % 64;   if (m_f[1] > 59) m_f[1] = 0;
          m_f[2] = cap % 64;          if (m_f[2] > 59) m_f[2] = 0;
          m_phase = 1; m_entry = n_edge; m_last = n_edge;
        end
      end else if (m_phase <= 3) begin
        if (m_ev[0]) begin
          if (m_phase == 3) begin
            m_phase = 4; m_ow = 1;
          end else begin
            m_phase++; m_entry = n_edge; m_last = n_edge;
          end
        end else if (m_ev != 0) begin
          m_last = n_edge;
          if (m_ev[1] != m_ev[2]) begin
            lim = (m_phase == 1) ? 24 : 60;
            m_f[m_phase-1] = (m_f[m_phase-1] + (m_ev[1] ? 1 : lim - 1)) % lim;
          end
        end else if (n_edge - m_last == TO) begin
          m_phase = 0;
        end
      end else begin
        m_phase = 0;
      end
      s3 = s2; s2 = s1; s1 = {btn_dec, btn_inc, btn_mode};
    end
  end

  int          ow_pulses = 0, ow_cycles = 0;
  logic [16:0] ow_val = '0, prev_set = '0;
  logic        prev_ow = 1'b0;
  bit          exp_blink;

  always @(negedge clk) begin
    exp_blink = (m_phase >= 1 && m_phase <= 3) && (((n_edge - m_entry) / BL) % 2 == 0);
    chk("time_set", 32'(time_set), word(m_f[0], m_f[1], m_f[2]));
    chk("time_ow", 32'(time_ow), 32'(m_ow));
    chk("set_active", 32'(set_active), 32'(m_phase != 0));
    chk("field_sel", 32'(field_sel), (m_phase >= 1 && m_phase <= 3) ? m_phase : 0);
    chk("blink", 32'(blink), 32'(exp_blink));
    if (time_ow === 1'b1) begin
      ow_cycles++;
      if (prev_ow !== 1'b1) ow_pulses++;
      ow_val = time_set;
      chk("ow_stable", 32'(time_set), 32'(prev_set));
    end
    prev_ow = time_ow;
    prev_set = time_set;
  end

  // mask = {dec, inc, mode}; the action lands 3 edges after the first edge.
  task automatic press(input logic [2:0] mask);
    @(posedge clk); #1;
    {btn_dec, btn_inc, btn_mode} = mask;
    repeat (2) @(posedge clk); #1;
    {btn_dec, btn_inc, btn_mode} = 3'b000;
    repeat (3) @(posedge clk); #1;
  endtask

  int base_p, base_c;

  initial begin
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_time_set", 32'(time_set), 0);
    chk("rst_time_ow", 32'(time_ow), 0);
    chk("rst_set_active", 32'(set_active), 0);
    chk("rst_field_sel", 32'(field_sel), 0);
    chk("rst_blink", 32'(blink), 0);

    // Basic set 12:34:56 -> 14:33:56
    time_cur = 17'(word(12, 34, 56));
    base_p = ow_pulses; base_c = ow_cycles;
    press(3'b001); chk("basic_fs1", 32'(field_sel), 1);
    chk("basic_cap", 32'(time_set), word(12, 34, 56));
    press(3'b010); press(3'b010);
    press(3'b001); chk("basic_fs2", 32'(field_sel), 2);
    press(3'b100);
    press(3'b001); chk("basic_fs3", 32'(field_sel), 3);
    chk("basic_edit", 32'(time_set), word(14, 33, 56));
    press(3'b001);
    chk("basic_pulses", ow_pulses - base_p, 1);
    chk("basic_width", ow_cycles - base_c, 1);
    chk("basic_ow_val", 32'(ow_val), word(14, 33, 56));
    chk("basic_fs0", 32'(field_sel), 0);
    chk("basic_idle", 32'(set_active), 0);

    // Wrap-around upward and downward
    time_cur = 17'(word(23, 59, 0));
    press(3'b001); press(3'b010); press(3'b001); press(3'b010); press(3'b001); press(3'b100);
    chk("wrap_up", 32'(time_set), word(0, 0, 59));
    press(3'b001);
    time_cur = '0;
    press(3'b001); press(3'b100); press(3'b001); press(3'b100); press(3'b001); press(3'b100);
    chk("wrap_down", 32'(time_set), word(23, 59, 59));
    press(3'b001);

    // Timeout: entry at edge 3, abort at edge 103
    time_cur = 17'(word(12, 34, 56));
    base_p = ow_pulses;
    @(posedge clk); #1 btn_mode = 1'b1;
    repeat (2) @(posedge clk); #1 btn_mode = 1'b0;
    @(posedge clk); #1;
    chk("to_enter", 32'(set_active), 1);
    repeat (99) @(posedge clk); #1;
    chk("to_edge102", 32'(set_active), 1);
    @(posedge clk); #1;
    chk("to_abort", 32'(set_active), 0);
    chk("to_fs", 32'(field_sel), 0);
    chk("to_no_ow", ow_pulses - base_p, 0);

    // Inc landing on the timeout edge keeps HOUR; blink phase checked on the way
    @(posedge clk); #1 btn_mode = 1'b1;
    repeat (2) @(posedge clk); #1 btn_mode = 1'b0;
    @(posedge clk); #1 chk("blink_e3", 32'(blink), 1);
    repeat (4) @(posedge clk); #1 chk("blink_e7", 32'(blink), 0);
    repeat (4) @(posedge clk); #1 chk("blink_e11", 32'(blink), 1);
    repeat (89) @(posedge clk); #1 btn_inc = 1'b1;
    repeat (3) @(posedge clk); #1 btn_inc = 1'b0;
    chk("to_inc_fs", 32'(field_sel), 1);
    chk("to_inc_val", 32'(time_set), word(13, 34, 56));

    // Simultaneous events
    press(3'b001);
    press(3'b011);
    chk("sim_mode_inc_fs", 32'(field_sel), 3);
    chk("sim_mode_inc_val", 32'(time_set), word(13, 34, 56));
    press(3'b110);
    chk("sim_inc_dec_val", 32'(time_set), word(13, 34, 56));
    chk("sim_inc_dec_fs", 32'(field_sel), 3);
    press(3'b001);

    // Invalid capture
    time_cur = 17'(word(31, 63, 60));
    press(3'b001);
    chk("invalid_cap", 32'(time_set), 0);
    press(3'b001); press(3'b001);

    // Async reset in COMMIT
    @(posedge clk); #1 btn_mode = 1'b1;
    repeat (2) @(posedge clk); #1 btn_mode = 1'b0;
    @(posedge clk); #3;
    chk("commit_ow", 32'(time_ow), 1);
    rst_n = 1'b0; #1;
    chk("arst_ow", 32'(time_ow), 0);
    chk("arst_active", 32'(set_active), 0);
    chk("arst_fs", 32'(field_sel), 0);
    chk("arst_set", 32'(time_set), 0);
    chk("arst_blink", 32'(blink), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle", 32'(set_active), 0);

    // Randomized buttons, captures and occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 3) == 0)  btn_inc = ~btn_inc;
      if ($urandom_range(0, 3) == 0)  btn_dec = ~btn_dec;
      if ($urandom_range(0, 199) == 0) time_cur = 17'($urandom_range(0, 131071));
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    {btn_dec, btn_inc, btn_mode} = 3'b000;
    repeat (5) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
